fsqrt_sched: RTL and testbench



---
 rtl/fsqrt_sched.sv | 146 ++++++++++++++
 tb/tb_fsqrt_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_sched.sv
// Round-robin issue scheduler sharing one fsqrt unit; result in slot 2+LAT cycles after accept.
// Optional FSQRT_SCHED_SPECIAL_EN: negative / inf / NaN operands bypass the unit and answer in 1 cycle.
module fsqrt_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [NREQ*32-1:0]   resp_y,
  output logic [NREQ-1:0]      resp_exc,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          fu_x,
  input  logic [31:0]          fu_y,
  input  logic                 fu_exc
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][31:0] req_x_a;
  logic [NREQ-1:0]       busy_q, busy_d;
  logic [NREQ-1:0]       elig;
  logic [IDW-1:0]        rr_q, rr_d;
  logic                  gnt_vld;
  logic [IDW-1:0]        gnt_id;
  logic [31:0]           gnt_x;
  logic                  bypass;
  logic                  issue;
  logic [IDW:0]          cand_sum;
  logic [IDW-1:0]        cand;
  logic [31:0]           fu_x_q, fu_x_d;
  logic [LAT:0]          tag_vld_q, tag_vld_d;
  logic [LAT:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NREQ-1:0]       resp_vld_q, resp_vld_d;
  logic [NREQ-1:0]       resp_exc_q, resp_exc_d;
  logic [NREQ-1:0][31:0] resp_y_q, resp_y_d;

  assign req_x_a = req_x;
  // Eligibility is masked in reset so req_ready reads 0 while rst is high.
  assign elig    = req_valid & ~busy_q & {NREQ{~rst}};

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, rr_q} + (IDW+1)'(i);
      if (cand_sum >= (IDW+1)'(NREQ)) cand_sum = cand_sum - (IDW+1)'(NREQ);
      cand = cand_sum[IDW-1:0];
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign gnt_x = req_x_a[gnt_id];

`ifdef FSQRT_SCHED_SPECIAL_EN
  assign bypass = gnt_vld & (gnt_x[31] | (&gnt_x[30:23]));
`else
  assign bypass = 1'b0;
`endif

  assign issue = gnt_vld & ~bypass;

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
  end

  assign fu_x_d = issue ? gnt_x : fu_x_q;

  // Tag pipeline: entry LAT lines up with the unit result for the operand issued LAT+1 cycles ago.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = issue;
    if (issue) tag_id_d[0] = gnt_id;
    for (int i = 1; i <= LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_comb begin
    busy_d     = busy_q;
    resp_vld_d = resp_vld_q;
    resp_y_d   = resp_y_q;
    resp_exc_d = resp_exc_q;
    for (int i = 0; i < NREQ; i++) begin
      if (resp_vld_q[i] && resp_ready[i]) begin
        resp_vld_d[i] = 1'b0;
        busy_d[i]     = 1'b0;
      end
      if (gnt_vld && gnt_id == IDW'(i)) busy_d[i] = 1'b1;
      if (tag_vld_q[LAT] && tag_id_q[LAT] == IDW'(i)) begin
        resp_vld_d[i] = 1'b1;
        resp_y_d[i]   = fu_y;
        resp_exc_d[i] = fu_exc;
      end
      if (bypass && gnt_id == IDW'(i)) begin
        resp_vld_d[i] = 1'b1;
        resp_y_d[i]   = 32'h7fc0_0000;
        resp_exc_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rr_q       <= '0;
      fu_x_q     <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      resp_vld_q <= '0;
      resp_y_q   <= '0;
      resp_exc_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rr_q       <= rr_d;
      fu_x_q     <= fu_x_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      resp_vld_q <= resp_vld_d;
      resp_y_q   <= resp_y_d;
      resp_exc_q <= resp_exc_d;
    end
  end

  assign fu_x       = fu_x_q;
  assign resp_valid = resp_vld_q;
  assign resp_y     = resp_y_q;
  assign resp_exc   = resp_exc_q;

endmodule

// File: tb/tb_fsqrt_sched.sv
// Scoreboard bench for fsqrt_sched (NREQ=4, LAT=2) with a table-driven fsqrt model.
module tb_fsqrt_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0][31:0] xin;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0][31:0] resp_y_a;
  logic [NREQ-1:0]       resp_exc;
  logic [NREQ-1:0]       resp_ready = '0;
  logic [31:0]           fu_x;
  logic [31:0]           fu_y;
  logic                  fu_exc;

  fsqrt_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(xin), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_y(resp_y_a), .resp_exc(resp_exc), .resp_ready(resp_ready),
    .fu_x(fu_x), .fu_y(fu_y), .fu_exc(fu_exc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed reciprocal square roots; returns {exc, y}.
  function automatic logic [32:0] unit_f(input logic [31:0] x);
    case (x)
      32'h4080_0000: return {1'b0, 32'h3f00_0000};
      32'h3f80_0000: return {1'b0, 32'h3f80_0000};
      32'h4180_0000: return {1'b0, 32'h3e80_0000};
      32'h3e80_0000: return {1'b0, 32'h4000_0000};
      32'hbf80_0000: return {1'b1, 32'h7fc0_0000};
      default:       return {1'b0, x ^ 32'h1234_5678};
    endcase
  endfunction

  // Unit model with LAT=2 register stages, deliberately not reset.
  logic [31:0] p0 = '0, p1 = '0;
  logic [32:0] fu_out;
  always @(posedge clk) begin
    p0 <= fu_x;
    p1 <= p0;
  end
  assign fu_out = unit_f(p1);
  assign fu_y   = fu_out[31:0];
  assign fu_exc = fu_out[32];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] y;
    logic        exc;
    int          at;
  } exp_t;

  exp_t exp_q[NREQ][$];
  exp_t cur[NREQ];
  bit   held[NREQ];
  int   gcnt[NREQ];
  exp_t e;
  logic [32:0] r;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        exp_q[i].delete();
        held[i] = 1'b0;
      end
    end else begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i]) begin
          if (!held[i]) begin
            if (exp_q[i].size() == 0) begin
              chk($sformatf("unexpected_resp%0d", i), resp_valid[i], 0);
            end else begin
              cur[i]  = exp_q[i].pop_front();
              held[i] = 1'b1;
              chk($sformatf("resp_cycle%0d", i), cyc, cur[i].at);
              chk($sformatf("resp_y%0d", i), resp_y_a[i], cur[i].y);
              chk($sformatf("resp_exc%0d", i), resp_exc[i], cur[i].exc);
            end
          end else begin
            chk($sformatf("hold_y%0d", i), resp_y_a[i], cur[i].y);
            chk($sformatf("hold_exc%0d", i), resp_exc[i], cur[i].exc);
          end
          if (resp_ready[i]) held[i] = 1'b0;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          gcnt[i]++;
          r    = unit_f(xin[i]);
          e.y   = r[31:0];
          e.exc = r[32];
          e.at  = cyc + 2 + LAT;
`ifdef FSQRT_SCHED_SPECIAL_EN
          if (xin[i][31] || (&xin[i][30:23])) begin
            e.y   = 32'h7fc0_0000;
            e.exc = 1'b1;
            e.at  = cyc + 1;
          end
`endif
          exp_q[i].push_back(e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    req_valid  = '0;
    resp_ready = '1;
    tick(LAT + 6);
    for (int i = 0; i < NREQ; i++) chk($sformatf("%s_missing%0d", name, i), exp_q[i].size(), 0);
  endtask

  initial begin
    xin = '0;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;

    // Reset state, with requests asserted during reset
    rst = 1'b1;
    req_valid = '1;
    tick(2);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_y", resp_y_a, 0);
    chk("rst_resp_exc", resp_exc, 0);
    chk("rst_fu_x", fu_x, 0);

    // Single requester: 4.0 -> 0.5, held until consumed, no regrant while busy
    tick();
    xin[0] = 32'h4080_0000;
    req_valid = 4'b0001;
    resp_ready = '0;
    @(negedge clk);
    chk("t1_grant", req_ready, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) xin[0] = 32'h3e80_0000;
      if (k == 8) resp_ready = 4'b0001;
      @(negedge clk);
      if (k == 1) chk("t1_fu_x", fu_x, 32'h4080_0000);
      chk($sformatf("t1_busy_k%0d", k), req_ready, 0);
    end
    tick();
    @(negedge clk);
    chk("t1_regrant", req_ready, 4'b0001);
    tick();
    drain("t1");

    // Round-robin fairness with immediate consumption
    do_reset();
    xin = {32'h3e80_0000, 32'h4180_0000, 32'h3f80_0000, 32'h4080_0000};
    resp_ready = '1;
    req_valid = '1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("fair_k%0d", k), req_ready, (k % 5 < 4) ? (4'b0001 << (k % 5)) : 4'b0000);
      tick();
    end
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    tick(1000);
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_count%0d", i), gcnt[i], 200);
    drain("fair");

    // Back-to-back grants to 1 then 2, then pointer wrap 3 -> 0
    do_reset();
    xin[1] = 32'h3f80_0000;
    xin[2] = 32'h4180_0000;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("lat_g1", req_ready, 4'b0010);
    tick();
    @(negedge clk);
    chk("lat_g2", req_ready, 4'b0100);
    chk("lat_fu_x1", fu_x, 32'h3f80_0000);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("lat_fu_x2", fu_x, 32'h4180_0000);
    tick();
    xin[3] = 32'h4080_0000;
    xin[0] = 32'h3f80_0000;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("wrap_g3", req_ready, 4'b1000);
    tick();
    @(negedge clk);
    chk("wrap_g0", req_ready, 4'b0001);
    tick();
    drain("lat");

    // Exception operand -1.0
    xin[3] = 32'hbf80_0000;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("exc_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    @(negedge clk);
`ifdef FSQRT_SCHED_SPECIAL_EN
    chk("exc_fu_x_held", fu_x, 32'h3f80_0000);
`else
    chk("exc_fu_x", fu_x, 32'hbf80_0000);
`endif
    drain("exc");

    // Back-pressure on requester 2
    do_reset();
    xin = {32'h3f80_0000, 32'h4180_0000, 32'h3e80_0000, 32'h4080_0000};
    resp_ready = 4'b1011;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    req_valid = '1;
    tick(3);
    chk("bp_first_grant2", gcnt[2], 1);
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    tick(20);
    chk("bp_no_grant2", gcnt[2], 0);
    chk("bp_served0", 64'(gcnt[0] >= 3), 1);
    chk("bp_served1", 64'(gcnt[1] >= 3), 1);
    chk("bp_served3", 64'(gcnt[3] >= 3), 1);
    resp_ready = '1;
    gcnt[2] = 0;
    tick(10);
    chk("bp_resume2", 64'(gcnt[2] > 0), 1);
    drain("bp");

    // Reset one cycle after a grant
    do_reset();
    xin[1] = 32'h3f80_0000;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rmf_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rmf_resp_valid", resp_valid, 0);
    chk("rmf_resp_y", resp_y_a, 0);
    chk("rmf_resp_exc", resp_exc, 0);
    chk("rmf_fu_x", fu_x, 0);
    chk("rmf_req_ready", req_ready, 0);
    tick();
    xin[3] = 32'h4080_0000;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("rmf_rr_restart", req_ready, 4'b0010);
    tick();
    @(negedge clk);
    chk("rmf_next", req_ready, 4'b1000);
    tick();
    drain("rmf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
